// File: rtl/rx_frame_sync.sv
// rx_frame_sync
//   Hunts for the 802.15.4 preamble (a run of zero bits) and the SFD in the
//   recovered serial bit stream. It then deserialises the PHR and PSDU, LSB
//   first, and writes whole bytes into the downstream RX FIFO.
//
// Ports
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   cdr_lock      CDR locked; low forces a resync and drops any frame
//   bit_in        recovered bit, sampled only when bit_valid=1
//   bit_valid     one-cycle strobe per recovered bit
//   fifo_full     downstream FIFO full
//   byte_out      assembled byte (PHR first, then payload); holds the last value
//   byte_valid    one-cycle FIFO write strobe
//   frame_active  high while receiving the PHR or the payload
//   frame_len     PSDU length of the current or last accepted frame
//   sfd_detected  one-cycle pulse on an SFD match
//   frame_done    one-cycle pulse, coincident with the last payload byte_valid
//   frame_err     one-cycle pulse on a frame abort
module rx_frame_sync #(
  parameter int          PREAMBLE_MIN = 8,
  parameter logic [7:0]  SFD          = 8'hA7,
  parameter int          MAX_LEN      = 127,
  parameter int          BIT_TIMEOUT  = 1023
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cdr_lock,
  input  logic       bit_in,
  input  logic       bit_valid,
  input  logic       fifo_full,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_active,
  output logic [6:0] frame_len,
  output logic       sfd_detected,
  output logic       frame_done,
  output logic       frame_err
);

  localparam int              ZW        = $clog2(PREAMBLE_MIN + 1);
  localparam int              IW        = $clog2(BIT_TIMEOUT + 1);
  localparam logic [ZW-1:0]   ZERO_MAX  = ZW'(PREAMBLE_MIN);
  localparam logic [IW-1:0]   IDLE_MAX  = IW'(BIT_TIMEOUT);
  localparam logic [IW-1:0]   IDLE_ONE  = IW'(1);
  localparam logic [7:0]      MAX_LEN_W = 8'(MAX_LEN);

  // Bit 1 of the encoding is the "inside a frame" flag, so frame_active is
  // a direct register bit rather than a decode.
  typedef enum logic [1:0] {
    ST_HUNT    = 2'b00,
    ST_SFD     = 2'b01,
    ST_PHR     = 2'b10,
    ST_PAYLOAD = 2'b11
  } state_t;

  state_t          r_state;
  // Only bits [7:1] of the shift register are ever read again, so bit 0 is
  // not stored: r_sh holds sh[7:1].
  logic [6:0]      r_sh;
  logic [2:0]      r_bit_cnt;
  logic [ZW-1:0]   r_zero_cnt;
  logic            r_capture;
  logic [6:0]      r_byte_cnt;
  logic [IW-1:0]   r_idle_cnt;
  logic [7:0]      r_byte_out;
  logic            r_byte_valid;
  logic [6:0]      r_frame_len;
  logic            r_sfd_detected;
  logic            r_frame_done;
  logic            r_frame_err;

  logic [7:0]      w_byte;
  logic            w_byte_done;
  logic            w_in_frame;
  logic [6:0]      w_len;
  logic            w_len_ok;
  logic [ZW-1:0]   w_zero_inc;
  logic [6:0]      w_byte_cnt_nxt;

  // Saturating increment of the preamble zero counter.
  function automatic logic [ZW-1:0] zero_sat_inc(input logic [ZW-1:0] cnt);
    if (cnt >= ZERO_MAX) begin
      return cnt;
    end else begin
      return cnt + ZW'(1);
    end
  endfunction

  assign w_byte         = {bit_in, r_sh};
  assign w_byte_done    = (r_bit_cnt == 3'd7);
  assign w_in_frame     = r_state[1];
  assign w_len          = w_byte[6:0];
  assign w_len_ok       = (w_len != 7'd0) && ({1'b0, w_len} <= MAX_LEN_W);
  assign w_zero_inc     = zero_sat_inc(r_zero_cnt);
  assign w_byte_cnt_nxt = r_byte_cnt + 7'd1;

  // Frame sync state machine with all outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_HUNT;
      r_sh           <= 7'd0;
      r_bit_cnt      <= 3'd0;
      r_zero_cnt     <= '0;
      r_capture      <= 1'b0;
      r_byte_cnt     <= 7'd0;
      r_idle_cnt     <= '0;
      r_byte_out     <= 8'd0;
      r_byte_valid   <= 1'b0;
      r_frame_len    <= 7'd0;
      r_sfd_detected <= 1'b0;
      r_frame_done   <= 1'b0;
      r_frame_err    <= 1'b0;
    end else begin
      r_byte_valid   <= 1'b0;
      r_sfd_detected <= 1'b0;
      r_frame_done   <= 1'b0;
      r_frame_err    <= 1'b0;

      if (!cdr_lock) begin
        // Loss of lock: drop everything. This is an error only if a frame was in progress.
        r_frame_err <= w_in_frame;
        r_state     <= ST_HUNT;
        r_bit_cnt   <= 3'd0;
        r_zero_cnt  <= '0;
        r_capture   <= 1'b0;
        r_byte_cnt  <= 7'd0;
        r_idle_cnt  <= '0;
      end else if (bit_valid) begin
        // A bit arriving in the timeout cycle cancels the timeout.
        r_idle_cnt <= '0;
        case (r_state)
          ST_HUNT: begin
            if (bit_in) begin
              r_zero_cnt <= '0;
            end else begin
              r_zero_cnt <= w_zero_inc;
              if (w_zero_inc >= ZERO_MAX) begin
                r_state   <= ST_SFD;
                r_capture <= 1'b0;
                r_bit_cnt <= 3'd0;
              end else begin
                r_state <= ST_HUNT;
              end
            end
          end
          ST_SFD: begin
            if (!r_capture) begin
              // Zeros here are still preamble. The first 1 is bit 0 of the SFD.
              if (bit_in) begin
                r_capture <= 1'b1;
                r_sh      <= w_byte[7:1];
                r_bit_cnt <= 3'd1;
              end else begin
                r_capture <= 1'b0;
              end
            end else begin
              r_sh      <= w_byte[7:1];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (w_byte_done) begin
                r_capture <= 1'b0;
                if (w_byte == SFD) begin
                  r_sfd_detected <= 1'b1;
                  r_state        <= ST_PHR;
                end else begin
                  r_state    <= ST_HUNT;
                  r_zero_cnt <= '0;
                end
              end else begin
                r_capture <= 1'b1;
              end
            end
          end
          ST_PHR: begin
            r_sh      <= w_byte[7:1];
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_byte_done) begin
              if (!w_len_ok || fifo_full) begin
                r_frame_err <= 1'b1;
                r_state     <= ST_HUNT;
                r_zero_cnt  <= '0;
              end else begin
                r_frame_len  <= w_len;
                r_byte_out   <= w_byte;
                r_byte_valid <= 1'b1;
                r_byte_cnt   <= 7'd0;
                r_state      <= ST_PAYLOAD;
              end
            end else begin
              r_state <= ST_PHR;
            end
          end
          ST_PAYLOAD: begin
            r_sh      <= w_byte[7:1];
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_byte_done) begin
              if (fifo_full) begin
                // Overflow: the byte is lost, so the whole frame is abandoned.
                r_frame_err <= 1'b1;
                r_state     <= ST_HUNT;
                r_zero_cnt  <= '0;
                r_byte_cnt  <= 7'd0;
              end else begin
                r_byte_out   <= w_byte;
                r_byte_valid <= 1'b1;
                r_byte_cnt   <= w_byte_cnt_nxt;
                if (w_byte_cnt_nxt == r_frame_len) begin
                  r_frame_done <= 1'b1;
                  r_state      <= ST_HUNT;
                  r_zero_cnt   <= '0;
                  r_byte_cnt   <= 7'd0;
                end else begin
                  r_state <= ST_PAYLOAD;
                end
              end
            end else begin
              r_state <= ST_PAYLOAD;
            end
          end
          default: begin
            r_state <= ST_HUNT;
          end
        endcase
      end else if (w_in_frame) begin
        if (r_idle_cnt == IDLE_MAX) begin
          r_frame_err <= 1'b1;
          r_state     <= ST_HUNT;
          r_bit_cnt   <= 3'd0;
          r_zero_cnt  <= '0;
          r_byte_cnt  <= 7'd0;
          r_idle_cnt  <= '0;
        end else begin
          r_idle_cnt <= r_idle_cnt + IDLE_ONE;
        end
      end else begin
        r_idle_cnt <= '0;
      end
    end
  end

  assign byte_out     = r_byte_out;
  assign byte_valid   = r_byte_valid;
  assign frame_active = r_state[1];
  assign frame_len    = r_frame_len;
  assign sfd_detected = r_sfd_detected;
  assign frame_done   = r_frame_done;
  assign frame_err    = r_frame_err;

endmodule
